// File: rtl/dest_demux_pkg.sv
// Constants shared by the write-side demux and the read-side four-FIFO selector.
package dest_demux_pkg;
    localparam int DATA_W   = 10;
    localparam int DEST_HI  = 9;
    localparam int DEST_LO  = 8;
    localparam int NUM_DEST = 4;
    localparam int CNT_W    = 8;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } stage_st_e;
endpackage

// File: rtl/dest_demux_push_counter.sv
// Wrapping push counter with synchronous reset and increment enable.
module push_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset)   cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dest_demux.sv
// One-entry registered stage that steers each word to one of four FIFOs by its
// top two bits, stalling upstream while the addressed FIFO is full.
module dest_demux #(
    parameter int DATA_W = dest_demux_pkg::DATA_W,
    parameter int CNT_W  = dest_demux_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic [3:0]        fifo_full,
    output logic              pause,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        push,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);
    import dest_demux_pkg::*;

    stage_st_e                          state, state_nxt;
    logic [DATA_W-1:0]                  buf_data;
    logic [1:0]                         dest;
    logic                               take;
    logic [NUM_DEST-1:0][CNT_W-1:0]     cnt_arr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            buf_data <= '0;
        end else begin
            state <= state_nxt;
            if (take) buf_data <= data_in;
        end
    end

    always_comb begin
        dest      = buf_data[DATA_W-1 -: 2];
        push      = '0;
        pause     = 1'b0;
        state_nxt = state;
        if (state == LOADED) begin
            if (fifo_full[dest]) pause = 1'b1;
            else                 push[dest] = 1'b1;
        end
        take = valid_in & ~pause;
        case (state)
            EMPTY:   if (take) state_nxt = LOADED;
            // A stall keeps LOADED; a drain without refill empties the stage.
            LOADED:  if (!pause && !take) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign data_out = buf_data;

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
        push_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .en    (push[g]),
            .cnt   (cnt_arr[g])
        );
    end

    assign cnt0 = cnt_arr[0];
    assign cnt1 = cnt_arr[1];
    assign cnt2 = cnt_arr[2];
    assign cnt3 = cnt_arr[3];
endmodule
